// File: rtl/control_path.sv
// control_path: sequencer for the matrix-multiplier core.
// After reset it fills matrices A and B with a fixed pattern. It then computes
// C = A x B one element at a time. The multiply and the accumulate are done
// internally, and each result is written to C.
//
// Optional feature macro: CTRL_READBACK_EN. When defined, C is swept once with
// read strobes after the last write, before the block parks in DONE.
//
// Ports
//   clk, reset_n                     clock; asynchronous active-low reset
//   en_ReadMat_{A,B,C}               memory read strobes
//   en_WriteMat_{A,B,C}              memory write strobes
//   rowAddr_*/colAddr_*              element address (0 when not strobed)
//   writeData_{A,B,C}                write data (0 when not writing)
//   readData_{A,B}                   memory read data, valid the cycle after a read
//   readData_C                       accepted, not used
//   en_Mux                           accumulator source: 0 = zero, 1 = feedback
//   en_PPReg / en_FDReg              partial-product / accumulator load enables
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | one cycle after reset release, all outputs 0
// INIT     | write A(n)=n, B(n)=N*N-1-n for n = 0..N*N-1, row-major
// RD       | read A(i,k) and B(k,j)
// MUL      | readData valid; pp <= A*B (truncated)
// ACC      | acc <= (k==0 ? 0 : acc) + pp; loop to RD or go to WR
// WR       | write acc to C(i,j); next element, or finish
// READBACK | sweep C with read strobes (CTRL_READBACK_EN only)
// DONE     | all strobes 0 until reset
module control_path #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  en_ReadMat_A,
  output logic                  en_ReadMat_B,
  output logic                  en_ReadMat_C,
  output logic                  en_WriteMat_A,
  output logic                  en_WriteMat_B,
  output logic                  en_WriteMat_C,
  output logic [3:0]            rowAddr_A,
  output logic [3:0]            colAddr_A,
  output logic [3:0]            rowAddr_B,
  output logic [3:0]            colAddr_B,
  output logic [3:0]            rowAddr_C,
  output logic [3:0]            colAddr_C,
  output logic [DATA_WIDTH-1:0] writeData_A,
  output logic [DATA_WIDTH-1:0] writeData_B,
  output logic [DATA_WIDTH-1:0] writeData_C,
  input  logic [DATA_WIDTH-1:0] readData_A,
  input  logic [DATA_WIDTH-1:0] readData_B,
  input  logic [DATA_WIDTH-1:0] readData_C,
  output logic                  en_Mux,
  output logic                  en_PPReg,
  output logic                  en_FDReg
);

  typedef enum logic [2:0] {IDLE, INIT, RD, MUL, ACC, WR, READBACK, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N - 1);
  localparam logic [7:0] LAST_N   = 8'(N * N - 1);

  state_t                state;
  logic                  idleDone;
  logic [7:0]            n;
  logic [3:0]            i, j, k;
  logic [DATA_WIDTH-1:0] pp, acc, accSum;
  logic [3:0]            nextRow, nextCol;
  logic                  lastElem;
  logic                  unusedReadC;

  assign unusedReadC = ^readData_C;

  // (i,j) doubles as the row/col walker for INIT and READBACK, which avoids a
  // divide/modulo by N.
  always_comb begin
    nextCol  = (j == LAST_IDX) ? 4'd0 : j + 4'd1;
    nextRow  = (j == LAST_IDX) ? i + 4'd1 : i;
    lastElem = (i == LAST_IDX) && (j == LAST_IDX);
    accSum   = (k == 4'd0) ? pp : acc + pp;
  end

  // Outputs are registered: each branch loads the values the next state shows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idleDone      <= 1'b0;
      n             <= '0;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      pp            <= '0;
      acc           <= '0;
      en_ReadMat_A  <= 1'b0;
      en_ReadMat_B  <= 1'b0;
      en_ReadMat_C  <= 1'b0;
      en_WriteMat_A <= 1'b0;
      en_WriteMat_B <= 1'b0;
      en_WriteMat_C <= 1'b0;
      rowAddr_A     <= '0;
      colAddr_A     <= '0;
      rowAddr_B     <= '0;
      colAddr_B     <= '0;
      rowAddr_C     <= '0;
      colAddr_C     <= '0;
      writeData_A   <= '0;
      writeData_B   <= '0;
      writeData_C   <= '0;
      en_Mux        <= 1'b0;
      en_PPReg      <= 1'b0;
      en_FDReg      <= 1'b0;
    end else begin
      en_ReadMat_A  <= 1'b0;
      en_ReadMat_B  <= 1'b0;
      en_ReadMat_C  <= 1'b0;
      en_WriteMat_A <= 1'b0;
      en_WriteMat_B <= 1'b0;
      en_WriteMat_C <= 1'b0;
      rowAddr_A     <= '0;
      colAddr_A     <= '0;
      rowAddr_B     <= '0;
      colAddr_B     <= '0;
      rowAddr_C     <= '0;
      colAddr_C     <= '0;
      writeData_A   <= '0;
      writeData_B   <= '0;
      writeData_C   <= '0;
      en_Mux        <= 1'b0;
      en_PPReg      <= 1'b0;
      en_FDReg      <= 1'b0;
      case (state)
        IDLE: begin
          idleDone <= 1'b1;
          if (idleDone) begin
            state         <= INIT;
            n             <= '0;
            i             <= '0;
            j             <= '0;
            en_WriteMat_A <= 1'b1;
            en_WriteMat_B <= 1'b1;
            writeData_B   <= DATA_WIDTH'(LAST_N);
          end
        end
        INIT: begin
          if (n == LAST_N) begin
            state        <= RD;
            i            <= '0;
            j            <= '0;
            k            <= '0;
            en_ReadMat_A <= 1'b1;
            en_ReadMat_B <= 1'b1;
          end else begin
            n             <= n + 8'd1;
            i             <= nextRow;
            j             <= nextCol;
            en_WriteMat_A <= 1'b1;
            en_WriteMat_B <= 1'b1;
            rowAddr_A     <= nextRow;
            colAddr_A     <= nextCol;
            rowAddr_B     <= nextRow;
            colAddr_B     <= nextCol;
            writeData_A   <= DATA_WIDTH'(n + 8'd1);
            writeData_B   <= DATA_WIDTH'(LAST_N - n - 8'd1);
          end
        end
        RD: begin
          state    <= MUL;
          en_PPReg <= 1'b1;
        end
        MUL: begin
          pp       <= DATA_WIDTH'(readData_A * readData_B);
          state    <= ACC;
          en_FDReg <= 1'b1;
          en_Mux   <= (k != 4'd0);
        end
        ACC: begin
          acc <= accSum;
          if (k != LAST_IDX) begin
            k            <= k + 4'd1;
            state        <= RD;
            en_ReadMat_A <= 1'b1;
            en_ReadMat_B <= 1'b1;
            rowAddr_A    <= i;
            colAddr_A    <= k + 4'd1;
            rowAddr_B    <= k + 4'd1;
            colAddr_B    <= j;
          end else begin
            state         <= WR;
            en_WriteMat_C <= 1'b1;
            rowAddr_C     <= i;
            colAddr_C     <= j;
            writeData_C   <= accSum;
          end
        end
        WR: begin
          k <= '0;
          if (lastElem) begin
`ifdef CTRL_READBACK_EN
            state        <= READBACK;
            n            <= '0;
            i            <= '0;
            j            <= '0;
            en_ReadMat_C <= 1'b1;
`else
            state <= DONE;
`endif
          end else begin
            i            <= nextRow;
            j            <= nextCol;
            state        <= RD;
            en_ReadMat_A <= 1'b1;
            en_ReadMat_B <= 1'b1;
            rowAddr_A    <= nextRow;
            colAddr_B    <= nextCol;
          end
        end
`ifdef CTRL_READBACK_EN
        READBACK: begin
          if (n == LAST_N) begin
            state <= DONE;
          end else begin
            n            <= n + 8'd1;
            i            <= nextRow;
            j            <= nextCol;
            en_ReadMat_C <= 1'b1;
            rowAddr_C    <= nextRow;
            colAddr_C    <= nextCol;
          end
        end
`endif
        DONE: ;
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_path.sv
module tb_control_path;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int NN = N * N;
`ifdef CTRL_READBACK_EN
  localparam int END_CYC = 241;
`else
  localparam int END_CYC = 225;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en_ReadMat_A, en_ReadMat_B, en_ReadMat_C;
  logic          en_WriteMat_A, en_WriteMat_B, en_WriteMat_C;
  logic [3:0]    rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C, colAddr_C;
  logic [DW-1:0] writeData_A, writeData_B, writeData_C;
  logic [DW-1:0] readData_A = '0, readData_B = '0, readData_C = '0;
  logic          en_Mux, en_PPReg, en_FDReg;
  logic          anyOut;
  logic          scramble = 1'b0;

  logic [DW-1:0] memA [NN];
  logic [DW-1:0] memB [NN];
  logic [DW-1:0] memC [NN];

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int            c;
    int            r;
    int            col;
    logic [DW-1:0] d;
  } sbEntry_t;
  sbEntry_t sb[$];

  control_path #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .en_ReadMat_A(en_ReadMat_A), .en_ReadMat_B(en_ReadMat_B), .en_ReadMat_C(en_ReadMat_C),
    .en_WriteMat_A(en_WriteMat_A), .en_WriteMat_B(en_WriteMat_B), .en_WriteMat_C(en_WriteMat_C),
    .rowAddr_A(rowAddr_A), .colAddr_A(colAddr_A),
    .rowAddr_B(rowAddr_B), .colAddr_B(colAddr_B),
    .rowAddr_C(rowAddr_C), .colAddr_C(colAddr_C),
    .writeData_A(writeData_A), .writeData_B(writeData_B), .writeData_C(writeData_C),
    .readData_A(readData_A), .readData_B(readData_B), .readData_C(readData_C),
    .en_Mux(en_Mux), .en_PPReg(en_PPReg), .en_FDReg(en_FDReg)
  );

  always #5 clk = ~clk;

  assign anyOut = |{en_ReadMat_A, en_ReadMat_B, en_ReadMat_C, en_WriteMat_A, en_WriteMat_B,
                    en_WriteMat_C, rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C,
                    colAddr_C, writeData_A, writeData_B, writeData_C, en_Mux, en_PPReg, en_FDReg};

  // Cycle 0 is the first rising edge with reset_n high.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= -1;
    else          cyc <= cyc + 1;
  end

  // Synchronous memories: write on the edge ending the strobe cycle, read data
  // valid in the following cycle.
  always @(posedge clk) begin
    if (scramble) begin
      for (int x = 0; x < NN; x++) begin
        memA[x] <= 8'hFF;
        memB[x] <= 8'hFF;
      end
    end else begin
      if (en_WriteMat_A) memA[rowAddr_A * N + colAddr_A] <= writeData_A;
      if (en_WriteMat_B) memB[rowAddr_B * N + colAddr_B] <= writeData_B;
    end
    if (en_WriteMat_C) memC[rowAddr_C * N + colAddr_C] <= writeData_C;
    if (en_ReadMat_A)  readData_A <= memA[rowAddr_A * N + colAddr_A];
    if (en_ReadMat_B)  readData_B <= memB[rowAddr_B * N + colAddr_B];
    if (en_ReadMat_C)  readData_C <= memC[rowAddr_C * N + colAddr_C];
  end

  // Golden C from the INIT pattern A(n)=n, B(n)=NN-1-n, plus the cycle each
  // element is written: start NN+1, 3N+1 cycles per element, WR last.
  task automatic loadScoreboard();
    sbEntry_t e;
    int s;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += (i * N + k) * (NN - 1 - (k * N + j));
        e.c   = NN + 1 + (i * N + j) * (3 * N + 1) + 3 * N;
        e.r   = i;
        e.col = j;
        e.d   = 8'(s % 256);
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (anyOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: outputs active=%b, required 0", anyOut);
    end
    reset_n = 1'b1;
    loadScoreboard();
    @(negedge clk);
    checks++;
    if (cyc !== 0 || anyOut !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle0: cyc=%0d active=%b, required cyc 0 active 0", cyc, anyOut);
    end
    @(negedge clk);
    checks++;
    if ({en_WriteMat_A, en_WriteMat_B, rowAddr_A, colAddr_A, writeData_A, writeData_B}
        !== {1'b1, 1'b1, 4'd0, 4'd0, 8'd0, 8'd15}) begin
      errors++;
      $display("FAIL init_first: wrA=%b wrB=%b addr=(%0d,%0d) dA=%0d dB=%0d, required 1 1 (0,0) 0 15",
               en_WriteMat_A, en_WriteMat_B, rowAddr_A, colAddr_A, writeData_A, writeData_B);
    end
  endtask

  task automatic test_init();
    int guard = 0;
    int nn;
    logic [3:0] r4, c4;
    while (cyc < NN && guard < 40) begin
      @(negedge clk);
      guard++;
      nn = cyc - 1;
      r4 = 4'(nn / N);
      c4 = 4'(nn % N);
      checks++;
      if ({en_WriteMat_A, en_WriteMat_B, en_ReadMat_A, rowAddr_A, colAddr_A, rowAddr_B, colAddr_B,
           writeData_A, writeData_B}
          !== {1'b1, 1'b1, 1'b0, r4, c4, r4, c4, 8'(nn), 8'(NN - 1 - nn)}) begin
        errors++;
        $display("FAIL init_sweep: cyc=%0d addrA=(%0d,%0d) dA=%0d dB=%0d, required (%0d,%0d) %0d %0d",
                 cyc, rowAddr_A, colAddr_A, writeData_A, writeData_B, r4, c4, nn, NN - 1 - nn);
      end
    end
    @(negedge clk);
    checks++;
    if (cyc !== NN + 1 ||
        {en_ReadMat_A, en_ReadMat_B, en_WriteMat_A, rowAddr_A, colAddr_A, rowAddr_B, colAddr_B}
        !== {1'b1, 1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL first_read: cyc=%0d rdA=%b rdB=%b wrA=%b, required cyc %0d 1 1 0 at (0,0)",
               cyc, en_ReadMat_A, en_ReadMat_B, en_WriteMat_A, NN + 1);
    end
  endtask

  task automatic test_compute();
    int guard = 0;
    int e, p, kk, sub, ei, ej;
    int ppCnt = 0, fdCnt = 0;
    logic [3:0] muxBits = '0;
    logic rd, wr, rc;
    logic [7:0] expStrobe;
    logic [15:0] expAddrAB;
    logic [3:0] expRowC, expColC;
    sbEntry_t s;
    while (cyc < END_CYC + 3 && guard < 400) begin
      @(negedge clk);
      guard++;
      rd = 1'b0; wr = 1'b0; kk = 0; sub = 3; ei = 0; ej = 0;
      if (cyc >= NN + 1 && cyc <= NN + NN * (3 * N + 1)) begin
        e  = (cyc - NN - 1) / (3 * N + 1);
        p  = (cyc - NN - 1) % (3 * N + 1);
        ei = e / N;
        ej = e % N;
        if (p == 3 * N) wr = 1'b1;
        else begin
          kk  = p / 3;
          sub = p % 3;
          rd  = (sub == 0);
        end
      end
`ifdef CTRL_READBACK_EN
      rc = (cyc >= 225 && cyc <= 240);
`else
      rc = 1'b0;
`endif
      expStrobe = {rd, rd, rc, 1'b0, 1'b0, wr, sub == 1, sub == 2};
      checks++;
      if ({en_ReadMat_A, en_ReadMat_B, en_ReadMat_C, en_WriteMat_A, en_WriteMat_B, en_WriteMat_C,
           en_PPReg, en_FDReg} !== expStrobe) begin
        errors++;
        $display("FAIL strobes: cyc=%0d got rdA,rdB,rdC,wrA,wrB,wrC,pp,fd=%b required %b", cyc,
                 {en_ReadMat_A, en_ReadMat_B, en_ReadMat_C, en_WriteMat_A, en_WriteMat_B,
                  en_WriteMat_C, en_PPReg, en_FDReg}, expStrobe);
      end
      checks++;
      if (en_Mux !== (sub == 2 && kk != 0)) begin
        errors++;
        $display("FAIL en_mux: cyc=%0d got %b required %b", cyc, en_Mux, (sub == 2 && kk != 0));
      end
      expAddrAB = rd ? {4'(ei), 4'(kk), 4'(kk), 4'(ej)} : 16'h0;
      checks++;
      if ({rowAddr_A, colAddr_A, rowAddr_B, colAddr_B} !== expAddrAB) begin
        errors++;
        $display("FAIL addr_ab: cyc=%0d got %h required %h", cyc,
                 {rowAddr_A, colAddr_A, rowAddr_B, colAddr_B}, expAddrAB);
      end
      expRowC = wr ? 4'(ei) : (rc ? 4'((cyc - 225) / N) : 4'd0);
      expColC = wr ? 4'(ej) : (rc ? 4'((cyc - 225) % N) : 4'd0);
      checks++;
      if ({rowAddr_C, colAddr_C} !== {expRowC, expColC}) begin
        errors++;
        $display("FAIL addr_c: cyc=%0d got (%0d,%0d) required (%0d,%0d)", cyc, rowAddr_C,
                 colAddr_C, expRowC, expColC);
      end
      if (en_WriteMat_C === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL c_write: cyc=%0d unexpected write, scoreboard empty", cyc);
        end else begin
          s = sb.pop_front();
          if (cyc !== s.c || rowAddr_C !== 4'(s.r) || colAddr_C !== 4'(s.col) ||
              writeData_C !== s.d) begin
            errors++;
            $display("FAIL c_write: got cyc=%0d (%0d,%0d) data=%h required cyc=%0d (%0d,%0d) data=%h",
                     cyc, rowAddr_C, colAddr_C, writeData_C, s.c, s.r, s.col, s.d);
          end
        end
      end else begin
        checks++;
        if (writeData_C !== '0) begin
          errors++;
          $display("FAIL wdata_c_idle: cyc=%0d got %h required 0", cyc, writeData_C);
        end
      end
      if (cyc <= NN + 3 * N + 1) begin
        if (en_PPReg === 1'b1) ppCnt++;
        if (en_FDReg === 1'b1) begin
          fdCnt++;
          muxBits = {en_Mux, muxBits[3:1]};
        end
      end
      if (cyc >= END_CYC) begin
        checks++;
        if (anyOut !== 1'b0) begin
          errors++;
          $display("FAIL done_quiet: cyc=%0d outputs active, required 0", cyc);
        end
      end
    end
    checks++;
    if (cyc < END_CYC + 3) begin
      errors++;
      $display("FAIL compute_timeout: reached cyc=%0d required %0d", cyc, END_CYC + 3);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL c_write_count: %0d writes missing, required 0", sb.size());
    end
    checks++;
    if (ppCnt != 4 || fdCnt != 4 || muxBits !== 4'b1110) begin
      errors++;
      $display("FAIL elem00_acc: pp=%0d fd=%0d mux=%b required 4 4 1110", ppCnt, fdCnt, muxBits);
    end
  endtask

  task automatic test_midrun_reset();
    int guard = 0;
    logic seen = 1'b0;
    logic memOk;
    sbEntry_t s;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    loadScoreboard();
    while (cyc < 100 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc !== 100 || en_FDReg !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_acc: cyc=%0d fd=%b required cyc 100 fd 1", cyc, en_FDReg);
    end
    #1 reset_n = 1'b0;
    scramble = 1'b1;
    #1;
    checks++;
    if (anyOut !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: outputs active=%b, required 0", anyOut);
    end
    repeat (2) @(negedge clk);
    scramble = 1'b0;
    reset_n = 1'b1;
    loadScoreboard();
    guard = 0;
    while (!seen && guard < 60) begin
      @(negedge clk);
      guard++;
      if (cyc == NN + 1) begin
        memOk = 1'b1;
        for (int x = 0; x < NN; x++)
          if (memA[x] !== 8'(x) || memB[x] !== 8'(NN - 1 - x)) memOk = 1'b0;
        checks++;
        if (!memOk) begin
          errors++;
          $display("FAIL rewrite_ab: A[5]=%h B[5]=%h required 05 0a", memA[5], memB[5]);
        end
      end
      if (en_WriteMat_C === 1'b1) begin
        seen = 1'b1;
        s = sb.pop_front();
        checks++;
        if (cyc !== s.c || rowAddr_C !== 4'd0 || colAddr_C !== 4'd0 || writeData_C !== 8'h22) begin
          errors++;
          $display("FAIL rerun_c00: got cyc=%0d (%0d,%0d) data=%h required cyc=%0d (0,0) data=22",
                   cyc, rowAddr_C, colAddr_C, writeData_C, s.c);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rerun_timeout: no C write by cyc=%0d", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_compute();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
